// File: rtl/rs_issue_queue.sv
// rs_issue_queue: reservation station with CDB operand wakeup and age-matrix oldest-ready select.
// Holds dispatched ops until both sources are ready, then issues one op per free functional unit.
module rs_issue_queue #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DISPATCH_W = 2,
    parameter int unsigned NUM_FU     = 3,
    parameter int unsigned CDB_W      = 2,
    parameter int unsigned PREG_W     = 7,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned PAYLOAD_W  = 48,
    localparam int unsigned FU_W      = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
    localparam int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_flush,
    input  logic [DISPATCH_W-1:0]                i_disp_valid,
    input  logic [DISPATCH_W-1:0][PREG_W-1:0]    i_disp_dst,
    input  logic [DISPATCH_W-1:0][PREG_W-1:0]    i_disp_src0_tag,
    input  logic [DISPATCH_W-1:0][PREG_W-1:0]    i_disp_src1_tag,
    input  logic [DISPATCH_W-1:0]                i_disp_src0_rdy,
    input  logic [DISPATCH_W-1:0]                i_disp_src1_rdy,
    input  logic [DISPATCH_W-1:0][DATA_W-1:0]    i_disp_src0_data,
    input  logic [DISPATCH_W-1:0][DATA_W-1:0]    i_disp_src1_data,
    input  logic [DISPATCH_W-1:0][FU_W-1:0]      i_disp_fu,
    input  logic [DISPATCH_W-1:0][PAYLOAD_W-1:0] i_disp_payload,
    output logic                                 o_disp_ready,
    input  logic [CDB_W-1:0]                     i_cdb_valid,
    input  logic [CDB_W-1:0][PREG_W-1:0]         i_cdb_tag,
    input  logic [CDB_W-1:0][DATA_W-1:0]         i_cdb_data,
    input  logic [NUM_FU-1:0]                    i_fu_free,
    output logic [NUM_FU-1:0]                    o_issue_valid,
    output logic [NUM_FU-1:0][PREG_W-1:0]        o_issue_dst,
    output logic [NUM_FU-1:0][DATA_W-1:0]        o_issue_src0,
    output logic [NUM_FU-1:0][DATA_W-1:0]        o_issue_src1,
    output logic [NUM_FU-1:0][PAYLOAD_W-1:0]     o_issue_payload,
    output logic [CNT_W-1:0]                     o_count
);

    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SLOT_W = (DISPATCH_W > 1) ? $clog2(DISPATCH_W) : 1;

    logic [DEPTH-1:0]            ent_valid;
    logic [DEPTH-1:0]            ent_s0_rdy;
    logic [DEPTH-1:0]            ent_s1_rdy;
    logic [FU_W-1:0]             ent_fu      [DEPTH];
    logic [PREG_W-1:0]           ent_dst     [DEPTH];
    logic [PREG_W-1:0]           ent_s0_tag  [DEPTH];
    logic [PREG_W-1:0]           ent_s1_tag  [DEPTH];
    logic [DATA_W-1:0]           ent_s0_data [DEPTH];
    logic [DATA_W-1:0]           ent_s1_data [DEPTH];
    logic [PAYLOAD_W-1:0]        ent_payload [DEPTH];
    // age_q[r][c] = 1 means entry r was dispatched before entry c
    logic [DEPTH-1:0][DEPTH-1:0] age_q;
    logic [DEPTH-1:0][DEPTH-1:0] age_d;

    logic [DEPTH-1:0]            alloc_hit;
    logic [SLOT_W-1:0]           alloc_slot  [DEPTH];
    logic                        placed;
    logic [CNT_W-1:0]            n_acc;
    logic [CNT_W-1:0]            n_iss;
    logic [DISPATCH_W-1:0]       d_s0_rdy;
    logic [DISPATCH_W-1:0]       d_s1_rdy;
    logic [DATA_W-1:0]           d_s0_data   [DISPATCH_W];
    logic [DATA_W-1:0]           d_s1_data   [DISPATCH_W];
    logic [DEPTH-1:0]            wk_s0;
    logic [DEPTH-1:0]            wk_s1;
    logic [DATA_W-1:0]           wk_s0_data  [DEPTH];
    logic [DATA_W-1:0]           wk_s1_data  [DEPTH];
    logic [DEPTH-1:0]            elig;
    logic [DEPTH-1:0]            beaten;
    logic [DEPTH-1:0]            iss;
    logic [NUM_FU-1:0]           sel_found;
    logic [IDX_W-1:0]            sel_idx     [NUM_FU];

    assign o_disp_ready = (32'(o_count) + DISPATCH_W) <= DEPTH;

    // Allocation: each accepted slot takes the lowest entry that is free at the start of the cycle
    always_comb begin
        alloc_hit = '0;
        n_acc     = '0;
        placed    = 1'b0;
        for (int i = 0; i < DEPTH; i++) alloc_slot[i] = '0;
        for (int d = 0; d < DISPATCH_W; d++) begin
            if (o_disp_ready && !i_flush && !i_rst && i_disp_valid[d]) begin
                placed = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (!placed && !ent_valid[i] && !alloc_hit[i]) begin
                        alloc_hit[i]  = 1'b1;
                        alloc_slot[i] = SLOT_W'(d);
                        placed        = 1'b1;
                    end
                end
                n_acc = n_acc + CNT_W'(1);
            end
        end
    end

    // Operand capture: descending scan so the lowest-numbered matching CDB bus wins
    always_comb begin
        for (int d = 0; d < DISPATCH_W; d++) begin
            d_s0_rdy[d]  = i_disp_src0_rdy[d];
            d_s1_rdy[d]  = i_disp_src1_rdy[d];
            d_s0_data[d] = i_disp_src0_data[d];
            d_s1_data[d] = i_disp_src1_data[d];
            for (int k = CDB_W - 1; k >= 0; k--) begin
                if (i_cdb_valid[k] && i_cdb_tag[k] == i_disp_src0_tag[d]) begin
                    d_s0_rdy[d]  = 1'b1;
                    d_s0_data[d] = i_cdb_data[k];
                end
                if (i_cdb_valid[k] && i_cdb_tag[k] == i_disp_src1_tag[d]) begin
                    d_s1_rdy[d]  = 1'b1;
                    d_s1_data[d] = i_cdb_data[k];
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            wk_s0[i]      = 1'b0;
            wk_s1[i]      = 1'b0;
            wk_s0_data[i] = '0;
            wk_s1_data[i] = '0;
            for (int k = CDB_W - 1; k >= 0; k--) begin
                if (!ent_s0_rdy[i] && i_cdb_valid[k] && i_cdb_tag[k] == ent_s0_tag[i]) begin
                    wk_s0[i]      = 1'b1;
                    wk_s0_data[i] = i_cdb_data[k];
                end
                if (!ent_s1_rdy[i] && i_cdb_valid[k] && i_cdb_tag[k] == ent_s1_tag[i]) begin
                    wk_s1[i]      = 1'b1;
                    wk_s1_data[i] = i_cdb_data[k];
                end
            end
        end
    end

    // Select: an eligible entry wins its FU unless an older eligible entry targets the same FU
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            elig[i] = 1'b0;
            for (int f = 0; f < NUM_FU; f++) begin
                if (ent_fu[i] == FU_W'(f) && i_fu_free[f]) begin
                    elig[i] = ent_valid[i] && ent_s0_rdy[i] && ent_s1_rdy[i];
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            beaten[i] = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && elig[j] && ent_fu[j] == ent_fu[i] && age_q[j][i]) beaten[i] = 1'b1;
            end
        end
        iss   = '0;
        n_iss = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            sel_found[f] = 1'b0;
            sel_idx[f]   = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (elig[i] && !beaten[i] && ent_fu[i] == FU_W'(f)) begin
                    sel_found[f] = 1'b1;
                    sel_idx[f]   = IDX_W'(i);
                end
            end
            if (sel_found[f]) begin
                iss[sel_idx[f]] = 1'b1;
                n_iss           = n_iss + CNT_W'(1);
            end
        end
    end

    // New entries are younger than every resident entry; same-cycle order follows slot index
    always_comb begin
        age_d = age_q;
        for (int r = 0; r < DEPTH; r++) begin
            for (int c = 0; c < DEPTH; c++) begin
                if (alloc_hit[r] && alloc_hit[c]) age_d[r][c] = alloc_slot[r] < alloc_slot[c];
                else if (alloc_hit[r])            age_d[r][c] = 1'b0;
                else if (alloc_hit[c])            age_d[r][c] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            ent_valid       <= '0;
            age_q           <= '0;
            o_count         <= '0;
            o_issue_valid   <= '0;
            o_issue_dst     <= '0;
            o_issue_src0    <= '0;
            o_issue_src1    <= '0;
            o_issue_payload <= '0;
        end else begin
            ent_valid     <= (ent_valid & ~iss) | alloc_hit;
            age_q         <= age_d;
            o_count       <= o_count + n_acc - n_iss;
            o_issue_valid <= sel_found;
            for (int f = 0; f < NUM_FU; f++) begin
                o_issue_dst[f]     <= sel_found[f] ? ent_dst[sel_idx[f]]     : '0;
                o_issue_src0[f]    <= sel_found[f] ? ent_s0_data[sel_idx[f]] : '0;
                o_issue_src1[f]    <= sel_found[f] ? ent_s1_data[sel_idx[f]] : '0;
                o_issue_payload[f] <= sel_found[f] ? ent_payload[sel_idx[f]] : '0;
            end
        end
    end

    // Entry fields need no reset; ent_valid gates every use
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_hit[i]) begin
                ent_fu[i]      <= i_disp_fu[alloc_slot[i]];
                ent_dst[i]     <= i_disp_dst[alloc_slot[i]];
                ent_s0_tag[i]  <= i_disp_src0_tag[alloc_slot[i]];
                ent_s1_tag[i]  <= i_disp_src1_tag[alloc_slot[i]];
                ent_s0_rdy[i]  <= d_s0_rdy[alloc_slot[i]];
                ent_s1_rdy[i]  <= d_s1_rdy[alloc_slot[i]];
                ent_s0_data[i] <= d_s0_data[alloc_slot[i]];
                ent_s1_data[i] <= d_s1_data[alloc_slot[i]];
                ent_payload[i] <= i_disp_payload[alloc_slot[i]];
            end else begin
                if (wk_s0[i]) begin
                    ent_s0_rdy[i]  <= 1'b1;
                    ent_s0_data[i] <= wk_s0_data[i];
                end
                if (wk_s1[i]) begin
                    ent_s1_rdy[i]  <= 1'b1;
                    ent_s1_data[i] <= wk_s1_data[i];
                end
            end
        end
    end

endmodule
